// File: rtl/dc_cmd_seq.sv
// Command sequencer in front of the D13 PIO bus interface: buffers host register
// requests, issues them one at a time, and injects an interrupt-register read on INT1.
module dc_cmd_seq #(
  parameter int         DEPTH    = 4,
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] INT_ADDR = 8'hC0,
  parameter int         GAP      = 2
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        I_REQ_VALID,
  output logic        O_REQ_READY,
  input  logic        I_REQ_READ,
  input  logic [7:0]  I_REQ_ADDR,
  input  logic [1:0]  I_REQ_WORDS,
  input  logic [31:0] I_REQ_WDATA,
  output logic        O_RSP_VALID,
  output logic [31:0] O_RSP_DATA,
  output logic        O_RSP_ERR,
  output logic        O_INT_VALID,
  output logic [31:0] O_INT_STATUS,
  input  logic        I_DC_INT1,
  output logic        O_START,
  output logic        O_READ,
  output logic        O_WRITE,
  output logic [7:0]  O_REG_ADDR,
  output logic [5:0]  O_REG_WORDS,
  output logic [31:0] O_REG_WDATA,
  input  logic [31:0] I_REG_RDATA,
  input  logic        I_DONE
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int GW = $clog2(GAP + 2);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

  typedef struct packed {
    logic        read;
    logic [7:0]  addr;
    logic [1:0]  words;
    logic [31:0] wdata;
  } req_t;

  state_t        state_reg, state_next;
  req_t          mem [DEPTH];
  req_t          head_req;
  logic [AW-1:0] head_reg, tail_reg;
  logic [AW:0]   count_reg;
  logic          push, pop, take_int;

  logic          int_meta_reg, int_sync_reg, int_prev_reg, int_pend_reg;

  logic          cmd_int_reg, cmd_read_reg, err_reg;
  logic [7:0]    cmd_addr_reg;
  logic [1:0]    cmd_words_reg;
  logic [31:0]   cmd_wdata_reg, rdata_reg;
  logic [TW-1:0] wcnt_reg;
  logic [GW-1:0] gcnt_reg;

  assign O_REQ_READY = (count_reg != (AW+1)'(DEPTH));
  assign push        = I_REQ_VALID & O_REQ_READY;
  assign take_int    = (state_reg == S_IDLE) & int_pend_reg;
  assign pop         = (state_reg == S_IDLE) & ~int_pend_reg & (count_reg != '0);
  assign head_req    = mem[head_reg];

  always_ff @(posedge I_CLK) begin
    if (push) mem[tail_reg] <= {I_REQ_READ, I_REQ_ADDR, I_REQ_WORDS, I_REQ_WDATA};
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + AW'(1);
      if (pop)  head_reg <= head_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // INT1 is asynchronous; only its synchronized rising edge requests a status read.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      int_meta_reg <= 1'b0;
      int_sync_reg <= 1'b0;
      int_prev_reg <= 1'b0;
      int_pend_reg <= 1'b0;
    end else begin
      int_meta_reg <= I_DC_INT1;
      int_sync_reg <= int_meta_reg;
      int_prev_reg <= int_sync_reg;
      int_pend_reg <= (int_pend_reg & ~take_int) | (int_sync_reg & ~int_prev_reg);
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      cmd_int_reg   <= 1'b0;
      cmd_read_reg  <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_words_reg <= '0;
      cmd_wdata_reg <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      wcnt_reg      <= '0;
      gcnt_reg      <= '0;
    end else begin
      if (take_int) begin
        cmd_int_reg   <= 1'b1;
        cmd_read_reg  <= 1'b1;
        cmd_addr_reg  <= INT_ADDR;
        cmd_words_reg <= 2'd2;
        cmd_wdata_reg <= '0;
      end else if (pop) begin
        cmd_int_reg   <= 1'b0;
        cmd_read_reg  <= head_req.read;
        cmd_addr_reg  <= head_req.addr;
        cmd_words_reg <= (head_req.words == 2'd3) ? 2'd2 : head_req.words;
        cmd_wdata_reg <= head_req.wdata;
      end
      case (state_reg)
        S_ISSUE: begin
          wcnt_reg <= '0;
          err_reg  <= 1'b0;
        end
        S_WAIT: begin
          if (I_DONE)                         rdata_reg <= I_REG_RDATA;
          else if (wcnt_reg == TW'(TIMEOUT))  err_reg   <= 1'b1;
          else                                wcnt_reg  <= wcnt_reg + TW'(1);
        end
        S_RESP:  gcnt_reg <= '0;
        S_GAP:   gcnt_reg <= gcnt_reg + GW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state_reg;
    O_START      = 1'b0;
    O_READ       = 1'b0;
    O_WRITE      = 1'b0;
    O_REG_ADDR   = '0;
    O_REG_WORDS  = '0;
    O_REG_WDATA  = '0;
    O_RSP_VALID  = 1'b0;
    O_RSP_DATA   = '0;
    O_RSP_ERR    = 1'b0;
    O_INT_VALID  = 1'b0;
    O_INT_STATUS = '0;
    case (state_reg)
      S_IDLE:  if (take_int | pop) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (I_DONE || wcnt_reg == TW'(TIMEOUT)) state_next = S_RESP;
      S_RESP:  state_next = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gcnt_reg == GW'(GAP - 1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state_reg == S_ISSUE) O_START = 1'b1;
    if (state_reg == S_ISSUE || state_reg == S_WAIT) begin
      O_READ      = cmd_read_reg;
      O_WRITE     = ~cmd_read_reg;
      O_REG_ADDR  = cmd_addr_reg;
      O_REG_WORDS = {4'd0, cmd_words_reg};
      O_REG_WDATA = cmd_wdata_reg;
    end
    // Interrupt reads report on the status port only; a timed-out one is dropped silently.
    if (state_reg == S_RESP) begin
      if (cmd_int_reg) begin
        O_INT_VALID  = ~err_reg;
        O_INT_STATUS = err_reg ? '0 : rdata_reg;
      end else begin
        O_RSP_VALID = 1'b1;
        O_RSP_ERR   = err_reg;
        O_RSP_DATA  = (cmd_read_reg & ~err_reg) ? rdata_reg : '0;
      end
    end
  end
endmodule

// File: tb/tb_dc_cmd_seq.sv
// Self-checking bench for dc_cmd_seq: a bus responder backed by a register table,
// a transaction monitor, and per-scenario tasks checked against a queue-based model.
module tb_dc_cmd_seq;
  localparam int TIMEOUT = 255;

  logic I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  logic I_RST, I_REQ_VALID, O_REQ_READY, I_REQ_READ;
  logic [7:0] I_REQ_ADDR;
  logic [1:0] I_REQ_WORDS;
  logic [31:0] I_REQ_WDATA;
  logic O_RSP_VALID, O_RSP_ERR, O_INT_VALID, I_DC_INT1, O_START, O_READ, O_WRITE, I_DONE;
  logic [31:0] O_RSP_DATA, O_INT_STATUS, O_REG_WDATA, I_REG_RDATA;
  logic [7:0] O_REG_ADDR;
  logic [5:0] O_REG_WORDS;

  dc_cmd_seq #(.DEPTH(4), .TIMEOUT(TIMEOUT), .INT_ADDR(8'hC0), .GAP(2)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_REQ_VALID(I_REQ_VALID), .O_REQ_READY(O_REQ_READY),
    .I_REQ_READ(I_REQ_READ), .I_REQ_ADDR(I_REQ_ADDR), .I_REQ_WORDS(I_REQ_WORDS),
    .I_REQ_WDATA(I_REQ_WDATA), .O_RSP_VALID(O_RSP_VALID), .O_RSP_DATA(O_RSP_DATA),
    .O_RSP_ERR(O_RSP_ERR), .O_INT_VALID(O_INT_VALID), .O_INT_STATUS(O_INT_STATUS),
    .I_DC_INT1(I_DC_INT1), .O_START(O_START), .O_READ(O_READ), .O_WRITE(O_WRITE),
    .O_REG_ADDR(O_REG_ADDR), .O_REG_WORDS(O_REG_WORDS), .O_REG_WDATA(O_REG_WDATA),
    .I_REG_RDATA(I_REG_RDATA), .I_DONE(I_DONE)
  );

  typedef struct { logic rd; logic wr; logic [7:0] addr; logic [5:0] words; logic [31:0] wdata; int cyc; } start_t;
  typedef struct { logic [31:0] data; logic err; int cyc; int done_cyc; } rsp_t;
  typedef struct { logic rd; logic [7:0] addr; logic [1:0] words; logic [31:0] wdata; } exp_req_t;

  int n_checks = 0, n_pass = 0, cyc = 0;
  logic [31:0] reg_file [256];
  bit bus_en = 1'b1, bus_rand = 1'b0, bus_pend = 1'b0, xfer_on = 1'b0;
  int bus_delay = 10, bus_cnt = 0, last_done = -1, holds_bad = 0;
  logic [7:0] bus_addr;
  start_t start_q[$];
  rsp_t rsp_q[$];
  logic [31:0] int_q[$];
  int int_cyc_q[$];
  exp_req_t exp_q[$];
  start_t xfer;

  // Bus responder and transaction monitor, sampling 1 time unit after each rising edge.
  initial begin
    start_t st;
    rsp_t r;
    I_DONE = 1'b0;
    I_REG_RDATA = '0;
    forever begin
      @(posedge I_CLK); #1;
      cyc++;
      I_DONE = 1'b0;
      I_REG_RDATA = $urandom;
      if (O_RSP_VALID) begin
        r.data = O_RSP_DATA; r.err = O_RSP_ERR; r.cyc = cyc; r.done_cyc = last_done;
        rsp_q.push_back(r);
        $display("rsp  cyc=%0d data=%08h err=%0b", cyc, O_RSP_DATA, O_RSP_ERR);
      end
      if (O_INT_VALID) begin
        int_q.push_back(O_INT_STATUS);
        int_cyc_q.push_back(cyc);
        $display("int  cyc=%0d status=%08h", cyc, O_INT_STATUS);
      end
      if (O_RSP_VALID || O_INT_VALID || I_RST) xfer_on = 1'b0;
      if (xfer_on && ({O_READ, O_WRITE, O_REG_ADDR, O_REG_WORDS, O_REG_WDATA} !==
                      {xfer.rd, xfer.wr, xfer.addr, xfer.words, xfer.wdata})) holds_bad++;
      if (O_START) begin
        st.rd = O_READ; st.wr = O_WRITE; st.addr = O_REG_ADDR; st.words = O_REG_WORDS;
        st.wdata = O_REG_WDATA; st.cyc = cyc;
        start_q.push_back(st);
        xfer = st; xfer_on = 1'b1;
        if (bus_en) begin
          bus_pend = 1'b1;
          bus_cnt = bus_rand ? int'($urandom_range(1, 8)) : bus_delay;
          bus_addr = O_REG_ADDR;
        end
      end else if (bus_pend) begin
        if (bus_cnt <= 1) begin
          I_DONE = 1'b1; I_REG_RDATA = reg_file[bus_addr]; bus_pend = 1'b0; last_done = cyc;
        end else bus_cnt--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge I_CLK); #1; end
  endtask

  task automatic clear_logs();
    start_q.delete(); rsp_q.delete(); int_q.delete(); int_cyc_q.delete(); exp_q.delete();
    holds_bad = 0;
  endtask

  task automatic push_req(input logic rd, input logic [7:0] a, input logic [1:0] w,
                          input logic [31:0] d, output int stalls);
    I_REQ_VALID = 1'b1; I_REQ_READ = rd; I_REQ_ADDR = a; I_REQ_WORDS = w; I_REQ_WDATA = d;
    stalls = 0;
    while (!O_REQ_READY && stalls < 2000) begin tick(1); stalls++; end
    if (stalls >= 2000) begin
      n_checks++;
      $display("FAIL push_timeout ready=%0b want=1", O_REQ_READY);
    end
    tick(1);
    I_REQ_VALID = 1'b0;
    exp_q.push_back('{rd, a, w, d});
  endtask

  task automatic wait_rsp(input int n, input int bound);
    int t = 0;
    while (rsp_q.size() < n && t < bound) begin tick(1); t++; end
  endtask

  function automatic start_t start_at(input int i);
    start_t s;
    s.rd = 1'bx; s.wr = 1'bx; s.addr = 'x; s.words = 'x; s.wdata = 'x; s.cyc = -1;
    if (i < start_q.size()) s = start_q[i];
    return s;
  endfunction

  function automatic rsp_t rsp_at(input int i);
    rsp_t r;
    r.data = 'x; r.err = 1'bx; r.cyc = -1; r.done_cyc = -2;
    if (i < rsp_q.size()) r = rsp_q[i];
    return r;
  endfunction

  function automatic logic [115:0] outs_now();
    return {O_START, O_READ, O_WRITE, O_REG_ADDR, O_REG_WORDS, O_REG_WDATA, O_RSP_VALID,
            O_RSP_DATA, O_RSP_ERR, O_INT_VALID, O_INT_STATUS};
  endfunction

  // Reference model: what the bus interface should see and what the host should get back.
  function automatic logic [47:0] model_start(input exp_req_t e);
    logic [5:0] w;
    w = (e.words == 2'd3) ? 6'd2 : {4'd0, e.words};
    return {e.rd, ~e.rd, e.addr, w, e.wdata};
  endfunction

  function automatic logic [32:0] model_rsp(input exp_req_t e);
    return {e.rd ? reg_file[e.addr] : 32'h0, 1'b0};
  endfunction

  task automatic test_reset();
    I_RST = 1'b1;
    tick(3);
    n_checks++; if (outs_now() !== '0) $display("FAIL reset.outs got=%h want=0", outs_now()); else n_pass++;
    n_checks++; if (O_REQ_READY !== 1'b1) $display("FAIL reset.ready got=%0b want=1", O_REQ_READY); else n_pass++;
    I_RST = 1'b0;
    tick(3);
    n_checks++; if (outs_now() !== '0) $display("FAIL idle.outs got=%h want=0", outs_now()); else n_pass++;
    n_checks++; if (O_REQ_READY !== 1'b1) $display("FAIL idle.ready got=%0b want=1", O_REQ_READY); else n_pass++;
  endtask

  task automatic test_write();
    int st; start_t s; rsp_t r;
    clear_logs(); bus_rand = 1'b0; bus_delay = 20;
    push_req(1'b0, 8'h20, 2'd2, 32'hBEEF1234, st);
    wait_rsp(1, 100);
    tick(8);
    s = start_at(0); r = rsp_at(0);
    n_checks++; if (start_q.size() !== 1) $display("FAIL write.starts got=%0d want=1", start_q.size()); else n_pass++;
    n_checks++; if ({s.rd, s.wr} !== 2'b01) $display("FAIL write.rdwr got=%b want=01", {s.rd, s.wr}); else n_pass++;
    n_checks++; if (s.words !== 6'd2) $display("FAIL write.words got=%0d want=2", s.words); else n_pass++;
    n_checks++; if ({s.addr, s.wdata} !== {8'h20, 32'hBEEF1234}) $display("FAIL write.addr_data got=%h/%h want=20/beef1234", s.addr, s.wdata); else n_pass++;
    n_checks++; if (rsp_q.size() !== 1) $display("FAIL write.rsps got=%0d want=1", rsp_q.size()); else n_pass++;
    n_checks++; if ({r.data, r.err} !== 33'h0) $display("FAIL write.rsp got=%h/%0b want=0/0", r.data, r.err); else n_pass++;
    n_checks++; if (r.cyc !== s.cyc + 21) $display("FAIL write.latency got=%0d want=%0d", r.cyc, s.cyc + 21); else n_pass++;
  endtask

  task automatic test_read();
    int st; start_t s; rsp_t r;
    clear_logs(); bus_delay = 5;
    push_req(1'b1, 8'hB4, 2'd1, 32'h0, st);
    wait_rsp(1, 100);
    tick(8);
    s = start_at(0); r = rsp_at(0);
    n_checks++; if ({s.rd, s.wr, s.addr, s.words} !== {2'b10, 8'hB4, 6'd1}) $display("FAIL read.start got=%b/%h/%0d want=10/b4/1", {s.rd, s.wr}, s.addr, s.words); else n_pass++;
    n_checks++; if ({r.data, r.err} !== {32'h00005A5A, 1'b0}) $display("FAIL read.rsp got=%h/%0b want=00005a5a/0", r.data, r.err); else n_pass++;
    n_checks++; if (r.cyc !== r.done_cyc + 1) $display("FAIL read.done_latency got=%0d want=%0d", r.cyc, r.done_cyc + 1); else n_pass++;
    n_checks++; if (r.cyc !== s.cyc + 6) $display("FAIL read.latency got=%0d want=%0d", r.cyc, s.cyc + 6); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int st, stalls; start_t s; rsp_t r;
    clear_logs(); bus_delay = 30; stalls = 0;
    for (int i = 0; i < 5; i++) begin
      push_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), $urandom, st);
      stalls += st;
    end
    // The first request leaves the FIFO before the rest arrive, so DEPTH+1 accepts fit.
    n_checks++; if (stalls !== 0) $display("FAIL b2b.stalls got=%0d want=0", stalls); else n_pass++;
    n_checks++; if (O_REQ_READY !== 1'b0) $display("FAIL b2b.full_ready got=%0b want=0", O_REQ_READY); else n_pass++;
    wait_rsp(5, 400);
    tick(8);
    n_checks++; if (rsp_q.size() !== 5) $display("FAIL b2b.rsps got=%0d want=5", rsp_q.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      s = start_at(i); r = rsp_at(i);
      n_checks++; if ({s.rd, s.wr, s.addr, s.words, s.wdata} !== model_start(exp_q[i])) $display("FAIL b2b.start%0d got=%h want=%h", i, {s.rd, s.wr, s.addr, s.words, s.wdata}, model_start(exp_q[i])); else n_pass++;
      n_checks++; if ({r.data, r.err} !== model_rsp(exp_q[i])) $display("FAIL b2b.rsp%0d got=%h want=%h", i, {r.data, r.err}, model_rsp(exp_q[i])); else n_pass++;
    end
    n_checks++; if (O_REQ_READY !== 1'b1) $display("FAIL b2b.ready_after got=%0b want=1", O_REQ_READY); else n_pass++;
  endtask

  task automatic test_interrupt();
    int st, t; start_t s; rsp_t r0, r1;
    clear_logs(); bus_delay = 40; t = 0;
    push_req(1'b1, 8'h33, 2'd2, $urandom, st);
    while (start_q.size() < 1 && t < 20) begin tick(1); t++; end
    push_req(1'b0, 8'h44, 2'd1, $urandom, st);
    push_req(1'b1, 8'h55, 2'd2, $urandom, st);
    I_DC_INT1 = 1'b1; tick(4); I_DC_INT1 = 1'b0;
    wait_rsp(3, 400);
    tick(8);
    n_checks++; if (start_q.size() !== 4) $display("FAIL int.starts got=%0d want=4", start_q.size()); else n_pass++;
    s = start_at(0);
    n_checks++; if (s.addr !== 8'h33) $display("FAIL int.first_addr got=%h want=33", s.addr); else n_pass++;
    s = start_at(1);
    n_checks++; if ({s.rd, s.wr, s.addr, s.words} !== {2'b10, 8'hC0, 6'd2}) $display("FAIL int.int_start got=%b/%h/%0d want=10/c0/2", {s.rd, s.wr}, s.addr, s.words); else n_pass++;
    n_checks++; if ({start_at(2).addr, start_at(3).addr} !== 16'h4455) $display("FAIL int.queue_order got=%h/%h want=44/55", start_at(2).addr, start_at(3).addr); else n_pass++;
    n_checks++; if (int_q.size() !== 1) $display("FAIL int.pulses got=%0d want=1", int_q.size()); else n_pass++;
    if (int_q.size() > 0) begin
      r0 = rsp_at(0); r1 = rsp_at(1);
      n_checks++; if (int_q[0] !== 32'h00000081) $display("FAIL int.status got=%h want=00000081", int_q[0]); else n_pass++;
      n_checks++; if (!(int_cyc_q[0] > r0.cyc && int_cyc_q[0] < r1.cyc)) $display("FAIL int.order got=%0d want_between=%0d..%0d", int_cyc_q[0], r0.cyc, r1.cyc); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      r0 = rsp_at(i);
      n_checks++; if ({r0.data, r0.err} !== model_rsp(exp_q[i])) $display("FAIL int.rsp%0d got=%h want=%h", i, {r0.data, r0.err}, model_rsp(exp_q[i])); else n_pass++;
    end
    n_checks++; if (holds_bad !== 0) $display("FAIL int.hold got=%0d want=0", holds_bad); else n_pass++;
  endtask

  task automatic test_timeout();
    int st; start_t s; rsp_t r;
    clear_logs(); bus_en = 1'b0;
    push_req(1'b1, 8'h66, 2'd1, $urandom, st);
    wait_rsp(1, 400);
    bus_en = 1'b1; bus_delay = 3;
    s = start_at(0); r = rsp_at(0);
    n_checks++; if ({r.data, r.err} !== {32'h0, 1'b1}) $display("FAIL tmo.rsp got=%h/%0b want=0/1", r.data, r.err); else n_pass++;
    n_checks++; if (r.cyc !== s.cyc + TIMEOUT + 2) $display("FAIL tmo.latency got=%0d want=%0d", r.cyc, s.cyc + TIMEOUT + 2); else n_pass++;
    push_req(1'b0, 8'h67, 2'd2, $urandom, st);
    wait_rsp(2, 100);
    tick(8);
    n_checks++; if (start_at(1).addr !== 8'h67) $display("FAIL tmo.next_start got=%h want=67", start_at(1).addr); else n_pass++;
    n_checks++; if ({rsp_at(1).data, rsp_at(1).err} !== 33'h0) $display("FAIL tmo.next_rsp got=%h/%0b want=0/0", rsp_at(1).data, rsp_at(1).err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int st, t;
    clear_logs(); bus_delay = 30; t = 0;
    push_req(1'b1, 8'h11, 2'd1, $urandom, st);
    while (start_q.size() < 1 && t < 20) begin tick(1); t++; end
    push_req(1'b0, 8'h21, 2'd2, $urandom, st);
    push_req(1'b1, 8'h31, 2'd2, $urandom, st);
    tick(3);
    I_RST = 1'b1;
    tick(1);
    n_checks++; if (outs_now() !== '0) $display("FAIL rstmid.outs got=%h want=0", outs_now()); else n_pass++;
    n_checks++; if (O_REQ_READY !== 1'b1) $display("FAIL rstmid.ready got=%0b want=1", O_REQ_READY); else n_pass++;
    tick(1);
    I_RST = 1'b0;
    tick(60);
    n_checks++; if ({start_q.size(), rsp_q.size(), int_q.size()} !== {32'd1, 32'd0, 32'd0}) $display("FAIL rstmid.quiet got=%0d/%0d/%0d want=1/0/0", start_q.size(), rsp_q.size(), int_q.size()); else n_pass++;
    push_req(1'b0, 8'h12, 2'd2, $urandom, st);
    wait_rsp(1, 100);
    tick(8);
    n_checks++; if (start_at(1).addr !== 8'h12) $display("FAIL rstmid.after_start got=%h want=12", start_at(1).addr); else n_pass++;
    n_checks++; if ({rsp_q.size(), rsp_at(0).err} !== {32'd1, 1'b0}) $display("FAIL rstmid.after_rsp got=%0d/%0b want=1/0", rsp_q.size(), rsp_at(0).err); else n_pass++;
  endtask

  task automatic test_random();
    int st; start_t s; rsp_t r;
    clear_logs(); bus_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      push_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), $urandom, st);
      tick(int'($urandom_range(0, 3)));
    end
    wait_rsp(24, 3000);
    tick(8);
    bus_rand = 1'b0;
    n_checks++; if ({start_q.size(), rsp_q.size()} !== {32'd24, 32'd24}) $display("FAIL rand.counts got=%0d/%0d want=24/24", start_q.size(), rsp_q.size()); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      s = start_at(i); r = rsp_at(i);
      n_checks++; if ({s.rd, s.wr, s.addr, s.words, s.wdata} !== model_start(exp_q[i])) $display("FAIL rand.start%0d got=%h want=%h", i, {s.rd, s.wr, s.addr, s.words, s.wdata}, model_start(exp_q[i])); else n_pass++;
      n_checks++; if ({r.data, r.err} !== model_rsp(exp_q[i])) $display("FAIL rand.rsp%0d got=%h want=%h", i, {r.data, r.err}, model_rsp(exp_q[i])); else n_pass++;
      n_checks++; if (r.cyc !== r.done_cyc + 1) $display("FAIL rand.latency%0d got=%0d want=%0d", i, r.cyc, r.done_cyc + 1); else n_pass++;
    end
    n_checks++; if (holds_bad !== 0) $display("FAIL rand.hold got=%0d want=0", holds_bad); else n_pass++;
  endtask

  initial begin
    I_RST = 1'b1; I_REQ_VALID = 1'b0; I_REQ_READ = 1'b0; I_REQ_ADDR = '0;
    I_REQ_WORDS = '0; I_REQ_WDATA = '0; I_DC_INT1 = 1'b0;
    for (int i = 0; i < 256; i++) reg_file[i] = $urandom;
    reg_file[8'hB4] = 32'h00005A5A;
    reg_file[8'hC0] = 32'h00000081;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_interrupt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
